// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with one-hot grant, break-before-make GAP cycle.
// Optional forced release after HOLD_MAX grant cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_8 #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] idx_q, idx_d;
    logic       valid_q, valid_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] win_s;
    logic       user_rel_s;
    logic       forced_s;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;
`endif

    if ((HOLD_MAX < 32'd1) || (HOLD_MAX > 32'd255)) begin : g_bad_hold_max
        $error("rr_arbiter_8: HOLD_MAX must be within 1..255");
    end

    // Winner search: scan offsets high-to-low so the lowest offset from ptr wins.
    function automatic logic [3:0] pick_winner(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] cand;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            cand = p + 3'(i);
            if (r[cand]) begin
                res = {1'b1, cand};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        ptr_d      = ptr_q;
        win_s      = pick_winner(req, ptr_q);
        user_rel_s = done | ~req[idx_q];
        forced_s   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        forced_s   = ~user_rel_s & (hold_cnt_q == HOLD_MAX_C);
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_s[3]) begin
                    state_d = ST_GRANT;
                    gnt_d   = 8'd1 << win_s[2:0];
                    idx_d   = win_s[2:0];
                    valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = 8'd1;
`endif
                end else begin
                    gnt_d   = 8'd0;
                    idx_d   = 3'd0;
                    valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                // A simultaneous done and withdrawal is one release: ptr advances once.
                if (user_rel_s || forced_s) begin
                    state_d = ST_GAP;
                    gnt_d   = 8'd0;
                    idx_d   = 3'd0;
                    valid_d = 1'b0;
                    ptr_d   = idx_q + 3'd1;
`ifdef ARB_TIMEOUT_EN
                    timeout_d = forced_s;
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : (hold_cnt_q + 8'd1);
`endif
                    state_d = ST_GRANT;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
                gnt_d   = 8'd0;
                idx_d   = 3'd0;
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 8'd0;
                idx_d   = 3'd0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            ptr_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter and timeout pulse flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: randomized and directed stimulus against a
// cycle-level reference model built from the round-robin / break-before-make rules.
module tb_rr_arbiter_8;

    localparam int HOLD = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  req;
    logic        done;
    logic [7:0]  gnt;
    logic [2:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout;
    logic [12:0] dut_word;

    int n_vec = 0;
    int n_err = 0;

    // reference model: current owner (-1 = none), gap pending, pointer, hold count
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_gap;
    bit m_to;

    rr_arbiter_8 #(.HOLD_MAX(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    assign dut_word = {gnt, gnt_idx, gnt_valid, timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_gap   = 1'b0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] r, input logic d);
        bit rel;
        bit forced;
        if (m_owner >= 0) begin
            rel    = (d == 1'b1) || (r[m_owner] == 1'b0);
            forced = 1'b0;
`ifdef ARB_TIMEOUT_EN
            forced = !rel && (m_hold == HOLD);
`endif
            if (rel || forced) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_gap   = 1'b1;
                m_to    = forced;
            end else begin
                if (m_hold < 255) m_hold++;
                m_to = 1'b0;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
            m_to  = 1'b0;
        end else begin
            m_to = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % 8] == 1'b1) begin
                    m_owner = (m_ptr + k) % 8;
                    m_hold  = 1;
                end
            end
        end
    endfunction

    function automatic logic [12:0] exp_word();
        logic [7:0] g;
        logic [2:0] i;
        logic       v;
        g = 8'h00;
        i = 3'd0;
        v = 1'b0;
        if (m_owner >= 0) begin
            g = 8'h01 << m_owner;
            i = 3'(m_owner);
            v = 1'b1;
        end
        return {g, i, v, m_to};
    endfunction

    task automatic step();
        model_step(req, done);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 8'hFF;
        done = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (dut_word !== 13'd0) begin
                n_err++;
                $display("FAIL reset_hold: got %h want %h", dut_word, 13'd0);
            end
        end
        rst = 1'b0;
        step();
        n_vec++;
        if (dut_word !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_first_grant: got %h want %h", dut_word, {8'h01, 3'd0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_rotation();
        int seen[$];
        int budget;
        do_reset();
        req    = 8'hFF;
        budget = 0;
        while (seen.size() < 9 && budget < 100) begin
            done = (m_owner >= 0) ? 1'b1 : 1'b0;
            step();
            budget++;
            n_vec++;
            if (dut_word !== exp_word()) begin
                n_err++;
                $display("FAIL rotation: got %h want %h", dut_word, exp_word());
            end
            if (gnt_valid === 1'b1) seen.push_back(int'(gnt_idx));
        end
        done = 1'b0;
        n_vec++;
        if (seen.size() != 9) begin
            n_err++;
            $display("FAIL rotation_budget: got %0d grants want 9", seen.size());
        end
        for (int k = 0; k < seen.size(); k++) begin
            n_vec++;
            if (seen[k] != k % 8) begin
                n_err++;
                $display("FAIL rotation_order[%0d]: got %0d want %0d", k, seen[k], k % 8);
            end
        end
    endtask

    task automatic test_priority_jump();
        do_reset();
        req = 8'h08;
        repeat (3) begin
            step();
            n_vec++;
            if (dut_word !== exp_word()) begin
                n_err++;
                $display("FAIL jump_hold: got %h want %h", dut_word, exp_word());
            end
        end
        req  = 8'h88;
        done = 1'b1;
        step();
        done = 1'b0;
        n_vec++;
        if (gnt !== 8'h00) begin
            n_err++;
            $display("FAIL jump_release: got %h want %h", gnt, 8'h00);
        end
        step();
        step();
        n_vec++;
        if (dut_word !== {8'h80, 3'd7, 1'b1, 1'b0} || dut_word !== exp_word()) begin
            n_err++;
            $display("FAIL jump_winner7: got %h want %h", dut_word, {8'h80, 3'd7, 1'b1, 1'b0});
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 8'h20;
        step();
        step();
        req = 8'h00;
        step();
        n_vec++;
        if (dut_word !== 13'd0 || dut_word !== exp_word()) begin
            n_err++;
            $display("FAIL withdraw_release: got %h want %h", dut_word, 13'd0);
        end
        req = 8'hFF;
        step();
        step();
        n_vec++;
        if (dut_word !== {8'h40, 3'd6, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL withdraw_next: got %h want %h", dut_word, {8'h40, 3'd6, 1'b1, 1'b0});
        end
        // done and withdrawal together must advance the pointer only once
        do_reset();
        req = 8'h20;
        step();
        req  = 8'h00;
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'hFF;
        step();
        step();
        n_vec++;
        if (dut_word !== {8'h40, 3'd6, 1'b1, 1'b0} || dut_word !== exp_word()) begin
            n_err++;
            $display("FAIL done_and_withdraw: got %h want %h", dut_word, {8'h40, 3'd6, 1'b1, 1'b0});
        end
    endtask

    task automatic test_idle_done();
        do_reset();
        req = 8'h00;
        repeat (4) begin
            done = 1'b1;
            step();
            done = 1'b0;
            step();
            n_vec++;
            if (dut_word !== 13'd0) begin
                n_err++;
                $display("FAIL idle_done: got %h want %h", dut_word, 13'd0);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'h04;
        step();
        step();
        n_vec++;
        if (dut_word !== exp_word()) begin
            n_err++;
            $display("FAIL async_pre: got %h want %h", dut_word, exp_word());
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (dut_word !== 13'd0) begin
            n_err++;
            $display("FAIL async_reset: got %h want %h", dut_word, 13'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 8'h00;
        model_reset();
    endtask

    task automatic test_timeout();
        int to_cnt;
        int g_cnt;
        int n_cyc;
        do_reset();
        req    = 8'h02;
        to_cnt = 0;
        g_cnt  = 0;
`ifdef ARB_TIMEOUT_EN
        n_cyc = 12;
`else
        n_cyc = 300;
`endif
        for (int c = 0; c < n_cyc; c++) begin
            step();
            n_vec++;
            if (dut_word !== exp_word()) begin
                n_err++;
                $display("FAIL timeout_cycle%0d: got %h want %h", c, dut_word, exp_word());
            end
            if (timeout === 1'b1) to_cnt++;
            if (gnt === 8'h02) g_cnt++;
        end
        n_vec++;
`ifdef ARB_TIMEOUT_EN
        // grants 1-4, pulse 5, idle 6, grants 7-10, pulse 11, idle 12
        if (to_cnt != 2 || g_cnt != 8) begin
            n_err++;
            $display("FAIL timeout_count: got pulses=%0d grants=%0d want pulses=2 grants=8", to_cnt, g_cnt);
        end
`else
        if (to_cnt != 0 || g_cnt != 300) begin
            n_err++;
            $display("FAIL no_timeout_hold: got pulses=%0d grants=%0d want pulses=0 grants=300", to_cnt, g_cnt);
        end
`endif
        req = 8'h00;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
            end
            done = ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0;
            step();
            n_vec++;
            if (dut_word !== exp_word()) begin
                n_err++;
                $display("FAIL random_cycle%0d: got %h want %h", c, dut_word, exp_word());
            end
        end
        done = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        model_reset();
        test_reset();
        test_rotation();
        test_priority_jump();
        test_withdraw();
        test_idle_done();
        test_async_reset();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
